cmp_sort_ctrl: RTL and testbench
================================

# cmp_sort_ctrl

Sequencer that buffers DEPTH unsigned words and sorts them ascending using one shared external magnitude comparator (l/g/e outputs), issuing one compare-and-swap per clock (bubble sort with early exit). It sits between a valid/ready producer and a valid/ready consumer. The comparator is the only arithmetic resource; this block owns its operand inputs.

## Interface
- WIDTH, 3, data and comparator operand width
- DEPTH, 4, words per sort batch (≥2)
- SWAP_W, 8, swap counter width (saturating)
---
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a word
- in_data  in  WIDTH  input word
- in_ready  out  1  block accepts a word (LOAD state only)
- out_valid  out  1  sorted word available (DRAIN state only)
- out_data  out  WIDTH  sorted word, ascending order
- out_ready  in  1  consumer accepts word
- cmp_a, cmp_b  out  WIDTH  comparator operands
- cmp_l, cmp_g, cmp_e  in  1  comparator result (a<b, a>b, a==b), combinational
- busy  out  1  state is SORT or DRAIN
- sort_done  out  1  one-cycle pulse on SORT→DRAIN
- swap_cnt  out  SWAP_W  swaps performed in current batch
- cmp_err  out  1  sticky: comparator result not one-hot during SORT

## Operation
- States: LOAD, SORT, DRAIN. Reset state LOAD.
- LOAD: in_ready=1. On in_valid&&in_ready write buf[wr_idx], wr_idx++. Accept of word DEPTH-1 → SORT; wr_idx→0, pass=0, j=0, swapped=0, swap_cnt→0.
- SORT: cmp_a=buf[j], cmp_b=buf[j+1]; results sampled same cycle.
  - cmp_g=1 → swap buf[j], buf[j+1] at edge; swapped=1; swap_cnt++ (saturate at all-ones).
  - cmp_l or cmp_e → no swap (ties stable).
  - j < DEPTH-2-pass → j++.
  - j == DEPTH-2-pass (end of pass): if no swap in this pass (including this cycle) or pass == DEPTH-2 → DRAIN, pulse sort_done; else pass++, j=0, swapped=0.
  - Not exactly one of l/g/e high → cmp_err=1 (sticky until rst); swap decision uses cmp_g only.
  - in_valid ignored (in_ready=0).
- DRAIN: out_valid=1, out_data=buf[rd_idx]. On out_valid&&out_ready rd_idx++; accept of word DEPTH-1 → LOAD, rd_idx→0. out_data stable while out_valid&&!out_ready.
- cmp_a/cmp_b = 0 outside SORT.
- swap_cnt holds its value through DRAIN and LOAD until next SORT entry.

## Timing
- Reset (async, immediate): state=LOAD, all indices 0, buf cleared to 0, in_ready=1, out_valid=0, out_data=0, cmp_a=cmp_b=0, busy=0, sort_done=0, swap_cnt=0, cmp_err=0.
- Reset mid-SORT or mid-DRAIN: batch discarded, no partial output.
- SORT length: pass k takes DEPTH-1-k cycles. Already-sorted input: DEPTH-1 cycles. Worst case: DEPTH(DEPTH-1)/2 cycles (6 for DEPTH=4).
- Edge accepting last input → first SORT cycle immediately follows; out_valid rises in the cycle after the last SORT cycle, same cycle sort_done=1.
- Throughput: one input per cycle in LOAD, one output per cycle in DRAIN with out_ready held high. DRAIN→LOAD: in_ready high in the cycle after the last output handshake.
- No overlap: new input is not accepted until the batch has fully drained.

## Test plan
- Sorted in 1,2,3,4 → 3 SORT cycles, swap_cnt=0, out 1,2,3,4, sort_done single pulse.
- Reverse in 7,5,3,0 → 6 SORT cycles, swap_cnt=6, out 0,3,5,7.
- Duplicates in 4,2,4,2 → 6 SORT cycles, swap_cnt=3, out 2,2,4,4; cmp_e cycles cause no swap.
- Back-pressure: out_ready toggled 1,0,0,1,… in DRAIN → out_data held while stalled, all 4 words delivered in order; in_valid=1 throughout SORT/DRAIN never accepted.
- rst pulsed during SORT cycle 2 of reverse batch → all outputs at reset values asynchronously; new batch 3,1,2,0 → out 0,1,2,3.
- Comparator model forced to l=g=e=0 on one SORT cycle → cmp_err=1 and stays 1 across subsequent batches until rst; no swap on that cycle.

Source files
------------

// File: rtl/cmp_sort_ctrl_if.sv
// cmp_sort_ctrl_if
// Valid/ready word stream used on both sides of the sort sequencer.
//   valid  - source has a word on data
//   data   - WIDTH-bit word
//   ready  - sink accepts the word this cycle
// master modport: the side that produces words; slave modport: the side that consumes them.
interface cmp_sort_ctrl_if #(
    parameter int WIDTH = 3
) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl
// Buffers DEPTH unsigned words from a valid/ready producer, sorts them ascending
// with bubble sort (one compare-and-swap per clock, early exit on a clean pass)
// using an external magnitude comparator, then streams them to a valid/ready consumer.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_bus  (slave)       input word stream, ready only while loading
//   out_bus (master)      sorted output stream, valid only while draining
//   cmp_a, cmp_b          comparator operands (zero outside sorting)
//   cmp_l, cmp_g, cmp_e   comparator result a<b, a>b, a==b (combinational)
//   busy                  sorting or draining
//   sort_done             one-cycle pulse when sorting finishes
//   swap_cnt              saturating count of swaps in the current batch
//   cmp_err               sticky flag: comparator result was not one-hot while sorting
//
// state | meaning
// ------+----------------------------------------------------------
// LOAD  | accepting words into mem[0..DEPTH-1]
// SORT  | comparing mem[j] with mem[j+1], swapping when a > b
// DRAIN | presenting mem[rd_idx] on out_bus until all words taken
module cmp_sort_ctrl #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 4,
    parameter int SWAP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cmp_sort_ctrl_if.slave        in_bus,
    cmp_sort_ctrl_if.master       out_bus,
    output logic [WIDTH-1:0]      cmp_a,
    output logic [WIDTH-1:0]      cmp_b,
    input  logic                  cmp_l,
    input  logic                  cmp_g,
    input  logic                  cmp_e,
    output logic                  busy,
    output logic                  sort_done,
    output logic [SWAP_W-1:0]     swap_cnt,
    output logic                  cmp_err
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);
    localparam logic [IDX_W:0]   PASS_SPAN = (IDX_W + 1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  j;
    logic [IDX_W-1:0]  pass;
    logic              swapped;

    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              sort_done_r;

    logic [IDX_W-1:0]  j_nxt;
    logic              end_of_pass;
    logic              cmp_onehot;
    logic              pass_swapped;

    assign j_nxt = j + IDX_W'(1);

    // The last compare of pass k sits at j == DEPTH-2-k; summed to avoid a signed subtract.
    assign end_of_pass = (({1'b0, j} + {1'b0, pass}) == PASS_SPAN);

    // Odd parity covers exactly-one and all-three; all-three is the only odd case with l&g.
    assign cmp_onehot = (cmp_l ^ cmp_g ^ cmp_e) && !(cmp_l && cmp_g);

    // Includes a swap decided in this very cycle so the last compare of a pass counts.
    assign pass_swapped = swapped | cmp_g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx      <= '0;
            rd_idx      <= '0;
            j           <= '0;
            pass        <= '0;
            swapped     <= 1'b0;
            swap_cnt    <= '0;
            cmp_err     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sort_done_r <= 1'b0;
        end else begin
            sort_done_r <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_bus.valid && in_ready_r) begin
                        mem[wr_idx] <= in_bus.data;
                        if (wr_idx == LAST_IDX) begin
                            wr_idx     <= '0;
                            j          <= '0;
                            pass       <= '0;
                            swapped    <= 1'b0;
                            swap_cnt   <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            state      <= SORT;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end

                SORT: begin
                    if (!cmp_onehot) begin
                        cmp_err <= 1'b1;
                    end
                    if (cmp_g) begin
                        mem[j]     <= mem[j_nxt];
                        mem[j_nxt] <= mem[j];
                        if (swap_cnt != '1) begin
                            swap_cnt <= swap_cnt + SWAP_W'(1);
                        end
                    end
                    if (!end_of_pass) begin
                        j       <= j_nxt;
                        swapped <= pass_swapped;
                    end else if (!pass_swapped || (pass == LAST_PASS)) begin
                        out_valid_r <= 1'b1;
                        sort_done_r <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        pass    <= pass + IDX_W'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (out_valid_r && out_bus.ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx      <= '0;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= LOAD;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmp_a = (state == SORT) ? mem[j]     : '0;
    assign cmp_b = (state == SORT) ? mem[j_nxt] : '0;

    assign in_bus.ready  = in_ready_r;
    assign out_bus.valid = out_valid_r;
    assign out_bus.data  = out_valid_r ? mem[rd_idx] : '0;
    assign busy          = busy_r;
    assign sort_done     = sort_done_r;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl
// Drives batches into cmp_sort_ctrl, models the comparator, and checks sorted
// output, SORT length, swap count, handshake behaviour, reset and error flag
// against a reference built from the sort's mathematical properties.
module tb_cmp_sort_ctrl;

    localparam int WIDTH  = 3;
    localparam int DEPTH  = 4;
    localparam int SWAP_W = 8;

    logic clk;
    logic rst;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic cmp_l, cmp_g, cmp_e;
    logic busy, sort_done, cmp_err;
    logic [SWAP_W-1:0] swap_cnt;
    bit   force_zero;
    bit   err_exp;

    int n_chk;
    int n_fail;

    cmp_sort_ctrl_if #(.WIDTH(WIDTH)) in_bus ();
    cmp_sort_ctrl_if #(.WIDTH(WIDTH)) out_bus ();

    cmp_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SWAP_W(SWAP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_l     (cmp_l),
        .cmp_g     (cmp_g),
        .cmp_e     (cmp_e),
        .busy      (busy),
        .sort_done (sort_done),
        .swap_cnt  (swap_cnt),
        .cmp_err   (cmp_err)
    );

    // external comparator, optionally faulted to all-zero
    assign cmp_l = !force_zero && (cmp_a <  cmp_b);
    assign cmp_g = !force_zero && (cmp_a >  cmp_b);
    assign cmp_e = !force_zero && (cmp_a == cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_words(input int w[4]);
        int t;
        for (int i = 0; i < DEPTH; i++) begin
            in_bus.data  = WIDTH'(w[i]);
            in_bus.valid = 1'b1;
            t = 0;
            while (!in_bus.ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("load_ready", int'(in_bus.ready), 1);
            @(negedge clk);
        end
        // keep offering a word that must never be taken while busy
        in_bus.data = WIDTH'(7);
    endtask

    // fault_at >= 0 is only used with input 2,1,3,4 faulted on the first compare:
    // the 2>1 swap is lost and the rest of pass 0 is clean, so the batch exits unsorted.
    task automatic run_batch(input int w[4], input bit bp, input int fault_at);
        int q[$];
        int got[$];
        int exp_inv, exp_cyc, maxl, l, passes;
        int sort_cyc, sd, t, ph, held;
        bit stalled;
        bit bp_pat[4];

        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(w[i]);
        q.sort();
        exp_inv = 0;
        maxl    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            l = 0;
            for (int k = 0; k < i; k++) if (w[k] > w[i]) l++;
            exp_inv += l;
            if (l > maxl) maxl = l;
        end
        // bubble sort needs max-left-displacement passes plus one clean pass, capped
        passes = maxl + 1;
        if (passes > DEPTH - 1) passes = DEPTH - 1;
        exp_cyc = 0;
        for (int k = 0; k < passes; k++) exp_cyc += DEPTH - 1 - k;
        if (fault_at >= 0) begin
            q = '{2, 1, 3, 4};
            exp_inv = 0;
            exp_cyc = DEPTH - 1;
        end

        load_words(w);

        sort_cyc = 0; sd = 0; t = 0; ph = 0; held = 0; stalled = 0;
        got.delete();
        while (got.size() < DEPTH && t < 300) begin
            force_zero = 1'b0;
            if (busy && !out_bus.valid) begin
                if (sort_cyc == fault_at) force_zero = 1'b1;
                sort_cyc++;
            end
            if (busy) chk("in_ready_busy", int'(in_bus.ready), 0);
            if (sort_done) begin
                sd++;
                chk("done_with_valid", int'(out_bus.valid), 1);
            end
            if (out_bus.valid) begin
                if (stalled) chk("hold_data", int'(out_bus.data), held);
                out_bus.ready = bp ? bp_pat[ph % 4] : 1'b1;
                ph++;
                if (out_bus.ready) begin
                    got.push_back(int'(out_bus.data));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = int'(out_bus.data);
                end
            end else begin
                out_bus.ready = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        force_zero = 1'b0;
        if (t >= 300) chk("timeout", 0, 1);

        chk("in_ready_after", int'(in_bus.ready), 1);
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b0;
        chk("busy_after", int'(busy), 0);
        chk("valid_after", int'(out_bus.valid), 0);
        chk("cmp_a_idle", int'(cmp_a), 0);
        chk("sort_cycles", sort_cyc, exp_cyc);
        chk("done_pulses", sd, 1);
        chk("swap_cnt", int'(swap_cnt), exp_inv);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < got.size()) chk($sformatf("out%0d", i), got[i], q[i]);
            else chk($sformatf("out%0d_missing", i), 0, 1);
        end
        chk("cmp_err", int'(cmp_err), int'(err_exp));
        @(negedge clk);
        chk("swap_cnt_hold", int'(swap_cnt), exp_inv);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", int'(in_bus.ready), 1);
        chk("rst_out_valid", int'(out_bus.valid), 0);
        chk("rst_out_data", int'(out_bus.data), 0);
        chk("rst_cmp_a", int'(cmp_a), 0);
        chk("rst_cmp_b", int'(cmp_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sort_done", int'(sort_done), 0);
        chk("rst_swap_cnt", int'(swap_cnt), 0);
        chk("rst_cmp_err", int'(cmp_err), 0);
    endtask

    initial begin
        int w[4];
        n_chk = 0;
        n_fail = 0;
        force_zero = 1'b0;
        err_exp = 1'b0;
        rst = 1'b1;
        in_bus.valid = 1'b0;
        in_bus.data = '0;
        out_bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        run_batch('{1, 2, 3, 4}, 1'b0, -1);
        run_batch('{7, 5, 3, 0}, 1'b0, -1);
        run_batch('{4, 2, 4, 2}, 1'b0, -1);
        run_batch('{6, 1, 5, 2}, 1'b1, -1);

        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < DEPTH; i++) w[i] = int'($urandom_range(0, 7));
            run_batch(w, 1'($urandom_range(0, 1)), -1);
        end

        // reset during the second SORT cycle of a reverse batch
        load_words('{7, 5, 3, 0});
        @(negedge clk);
        chk("mid_sort_busy", int'(busy), 1);
        in_bus.valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_batch('{3, 1, 2, 0}, 1'b0, -1);

        // comparator fault on the first compare, then flag must persist
        err_exp = 1'b1;
        run_batch('{2, 1, 3, 4}, 1'b0, 0);
        run_batch('{5, 0, 7, 3}, 1'b1, -1);
        rst = 1'b1;
        #1;
        chk("err_cleared", int'(cmp_err), 0);
        @(negedge clk);
        rst = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        run_batch('{0, 7, 7, 1}, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
